pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, PC and target width (>= 8).
- RESET_VEC, 0, pc_o value after reset.
- HALT_PC, 248, address at which fetch stops permanently.
- TRAP_VEC, 4, redirect address for traps and misaligned branches.
- CNT_W, 32, width of the fetch counter.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  clock; all state updates on the rising edge.
- start_i  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard stall; holds PC.
- branch_i  in  1  branch/jump redirect request.
- branch_target_i  in  XLEN  redirect address.
- trap_i  in  1  trap request.
- pc_o  out  XLEN  current fetch address.
- pc_plus4_o  out  XLEN  pc_o + 4, combinational.
- valid_o  out  1  pc_o is a valid fetch address this cycle.
- halted_o  out  1  unit is in HALT.
- misalign_o  out  1  one-cycle pulse: a misaligned branch was converted to a trap.
- fetch_cnt_o  out  CNT_W  number of PC advances since reset.

Function
REQ-003 The unit SHALL be a three-state FSM: BOOT, RUN, HALT.
REQ-004 BOOT SHALL last exactly one cycle after reset deassertion, with valid_o=0 and pc_o=RESET_VEC, then go to RUN unconditionally; all inputs are ignored in BOOT.
REQ-005 In RUN, valid_o SHALL be 1 and the next pc_o SHALL be chosen in this priority order:
- trap_i -> TRAP_VEC.
- branch_i with branch_target_i[1:0]!=0 -> TRAP_VEC, with misalign_o=1 on the following cycle.
- branch_i, aligned -> branch_target_i.
- stall_i -> pc_o held.
- otherwise -> pc_o + 4.
REQ-006 Trap and branch SHALL override stall_i; a redirect asserted during a stall is taken on that edge.
REQ-007 In RUN, if pc_o==HALT_PC and no trap_i or branch_i is present, the FSM SHALL enter HALT on the next edge and pc_o SHALL stay at HALT_PC; this applies whether or not stall_i is asserted.
REQ-008 In HALT, pc_o SHALL hold HALT_PC, valid_o SHALL be 0, halted_o SHALL be 1, and all inputs SHALL be ignored; only reset exits HALT.
REQ-009 All PC arithmetic SHALL be modulo 2^XLEN; incrementing from 2^XLEN-4 wraps to 0 with no flag.
REQ-010 fetch_cnt_o SHALL increment by 1 on every RUN edge where pc_o changes value or a redirect is taken, SHALL hold otherwise, and SHALL wrap modulo 2^CNT_W.
REQ-011 misalign_o SHALL be registered, high for exactly one cycle per offending branch, and 0 in BOOT and HALT.
REQ-012 pc_plus4_o SHALL equal pc_o+4 (modulo 2^XLEN) in every state.

Reset
REQ-013 start_i low SHALL immediately and asynchronously force: state=BOOT, pc_o=RESET_VEC, valid_o=0, halted_o=0, misalign_o=0, fetch_cnt_o=0.
REQ-014 Reset asserted mid-operation, including in HALT, SHALL fully reinitialise the unit; no state SHALL survive reset.

Verification
REQ-015 Sequential run: reset, release, no requests for 5 cycles -> pc_o = 0 (BOOT), 0, 4, 8, 12; fetch_cnt_o=3 at the end.
REQ-016 Stall vs branch: in RUN at pc_o=8, apply stall_i=1 for 2 cycles -> pc_o stays 8; then stall_i=1 with branch_i=1, target=0x40 -> pc_o=0x40 on the next cycle.
REQ-017 Misaligned branch and trap priority: branch_i=1 with target 0x42 -> pc_o=4 and misalign_o=1 for one cycle; trap_i=1 together with branch_i=1 (target 0x80) -> pc_o=4 and misalign_o=0.
REQ-018 Halt: branch to 248 -> next cycle FSM enters HALT, pc_o=248, halted_o=1, valid_o=0; branch_i, trap_i and stall_i applied afterwards -> no change.
REQ-019 Wrap and reset: with XLEN=8, run up to pc_o=252 -> next pc_o=0; assert start_i asynchronously mid-cycle -> outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencer choosing the next fetch address
// from trap, branch, stall and sequential-increment requests, with a fetch counter.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] HALT_PC   = XLEN'(248),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(4),
    parameter int              CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic             trap_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic             valid_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [XLEN-1:0]  pc_reg;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             misalign_reg;
    logic             misalign_next;

    logic [XLEN-1:0]  pc_inc;
    logic             target_misaligned;

    assign pc_inc            = pc_reg + XLEN'(4);
    assign target_misaligned = (branch_target_i[1:0] != 2'b00);

    // Priority: trap, branch (misaligned ones become traps), halt check, stall, increment.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        cnt_next      = cnt_reg;
        misalign_next = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (trap_i) begin
                    pc_next  = TRAP_VEC;
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (branch_i) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (target_misaligned) begin
                        pc_next       = TRAP_VEC;
                        misalign_next = 1'b1;
                    end else begin
                        pc_next = branch_target_i;
                    end
                end else if (pc_reg == HALT_PC) begin
                    // Halting wins over stall; the PC itself stays put.
                    state_next = ST_HALT;
                end else if (!stall_i) begin
                    pc_next  = pc_inc;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_BOOT;
                pc_next    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_VEC;
            cnt_reg      <= '0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            cnt_reg      <= cnt_next;
            misalign_reg <= misalign_next;
        end
    end

    assign pc_o        = pc_reg;
    assign pc_plus4_o  = pc_inc;
    assign valid_o     = (state_reg == ST_RUN);
    assign halted_o    = (state_reg == ST_HALT);
    assign misalign_o  = misalign_reg;
    assign fetch_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit at XLEN=8/CNT_W=8: directed scenarios then random requests,
// all checked against an arithmetic reference model of the fetch sequencer.
module tb_pc_unit;

    localparam int XL       = 8;
    localparam int CW       = 8;
    localparam int PC_MOD   = 256;
    localparam int CNT_MOD  = 256;
    localparam int M_HALT_PC = 248;
    localparam int M_TRAP    = 4;
    localparam int M_RESET   = 0;

    logic          clk;
    logic          start;
    logic          stall;
    logic          branch;
    logic [XL-1:0] target;
    logic          trap;
    logic [XL-1:0] pc;
    logic [XL-1:0] pc_plus4;
    logic          valid;
    logic          halted;
    logic          misalign;
    logic [CW-1:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0=boot, 1=run, 2=halt
    int          m_phase;
    int unsigned m_pc;
    int unsigned m_cnt;
    bit          m_mis;

    pc_unit #(.XLEN(XL), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .start_i        (start),
        .stall_i        (stall),
        .branch_i       (branch),
        .branch_target_i(target),
        .trap_i         (trap),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4),
        .valid_o        (valid),
        .halted_o       (halted),
        .misalign_o     (misalign),
        .fetch_cnt_o    (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    {24'd0, pc},        m_pc);
        chk({tag, ".pc4"},   {24'd0, pc_plus4},  (m_pc + 4) % PC_MOD);
        chk({tag, ".valid"}, {31'd0, valid},     (m_phase == 1) ? 32'd1 : 32'd0);
        chk({tag, ".halt"},  {31'd0, halted},    (m_phase == 2) ? 32'd1 : 32'd0);
        chk({tag, ".mis"},   {31'd0, misalign},  {31'd0, m_mis});
        chk({tag, ".cnt"},   {24'd0, fetch_cnt}, m_cnt);
        $display("%s: pc=%0h cnt=%0d valid=%0b halted=%0b mis=%0b",
                 tag, pc, fetch_cnt, valid, halted, misalign);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = M_RESET;
        m_cnt   = 0;
        m_mis   = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit b, input int unsigned t, input bit tr);
        int unsigned old_pc;
        bit          redirect;
        old_pc   = m_pc;
        redirect = 1'b0;
        m_mis    = 1'b0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (tr) begin
                m_pc = M_TRAP;
                redirect = 1'b1;
            end else if (b) begin
                redirect = 1'b1;
                if (t % 4 != 0) begin
                    m_pc  = M_TRAP;
                    m_mis = 1'b1;
                end else begin
                    m_pc = t;
                end
            end else if (m_pc == M_HALT_PC) begin
                m_phase = 2;
            end else if (!s) begin
                m_pc = (m_pc + 4) % PC_MOD;
            end
            if (m_pc != old_pc || redirect) m_cnt = (m_cnt + 1) % CNT_MOD;
        end
    endtask

    // Drive one set of requests, clock once, then compare against the model.
    task automatic step(input string tag, input bit s, input bit b, input int unsigned t, input bit tr);
        stall  = s;
        branch = b;
        target = t[XL-1:0];
        trap   = tr;
        @(posedge clk);
        model_edge(s, b, t, tr);
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle, check it took effect with no edge, hold, then release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        start = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        start = 1'b1;
        #1;
        check_all({tag, ".boot"});
    endtask

    initial begin
        start  = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        target = '0;
        trap   = 1'b0;
        model_reset();

        // Sequential run from reset
        do_reset("seq");
        chk("seq.boot_pc", {24'd0, pc}, 32'd0);
        for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, 0, 1'b0);
        chk("seq.pc12", {24'd0, pc}, 32'd12);
        chk("seq.cnt3", {24'd0, fetch_cnt}, 32'd3);

        // Stall versus branch
        do_reset("stl");
        for (int i = 0; i < 3; i++) step("stl.adv", 1'b0, 1'b0, 0, 1'b0);
        chk("stl.pc8", {24'd0, pc}, 32'd8);
        step("stl.hold", 1'b1, 1'b0, 0, 1'b0);
        step("stl.hold", 1'b1, 1'b0, 0, 1'b0);
        chk("stl.held8", {24'd0, pc}, 32'd8);
        step("stl.br", 1'b1, 1'b1, 'h40, 1'b0);
        chk("stl.pc40", {24'd0, pc}, 32'h40);

        // Misaligned branch and trap priority
        step("mis.br42", 1'b0, 1'b1, 'h42, 1'b0);
        chk("mis.pc4", {24'd0, pc}, 32'd4);
        chk("mis.pulse", {31'd0, misalign}, 32'd1);
        step("mis.next", 1'b0, 1'b0, 0, 1'b0);
        chk("mis.clear", {31'd0, misalign}, 32'd0);
        step("trp", 1'b0, 1'b1, 'h80, 1'b1);
        chk("trp.pc4", {24'd0, pc}, 32'd4);
        chk("trp.nomis", {31'd0, misalign}, 32'd0);

        // Halt entry and immunity to requests
        step("hlt.br", 1'b0, 1'b1, 248, 1'b0);
        step("hlt.enter", 1'b0, 1'b0, 0, 1'b0);
        chk("hlt.halted", {31'd0, halted}, 32'd1);
        chk("hlt.valid", {31'd0, valid}, 32'd0);
        step("hlt.br", 1'b0, 1'b1, 'h10, 1'b0);
        step("hlt.trap", 1'b0, 1'b0, 0, 1'b1);
        step("hlt.stall", 1'b1, 1'b0, 0, 1'b0);
        chk("hlt.pc248", {24'd0, pc}, 32'd248);

        // Reset out of HALT, then stalled arrival at HALT_PC still halts
        do_reset("hrst");
        step("hs.boot", 1'b0, 1'b0, 0, 1'b0);
        step("hs.br", 1'b0, 1'b1, 248, 1'b0);
        step("hs.stall", 1'b1, 1'b0, 0, 1'b0);
        chk("hs.halted", {31'd0, halted}, 32'd1);

        // Address wrap 252 -> 0
        do_reset("wrp");
        step("wrp.boot", 1'b0, 1'b0, 0, 1'b0);
        step("wrp.br", 1'b0, 1'b1, 252, 1'b0);
        chk("wrp.pc4_252", {24'd0, pc_plus4}, 32'd0);
        step("wrp.inc", 1'b0, 1'b0, 0, 1'b0);
        chk("wrp.pc0", {24'd0, pc}, 32'd0);

        // Counter wrap: repeated redirects to the same address still count
        do_reset("cw");
        step("cw.boot", 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 260; i++) step("cw", 1'b0, 1'b1, 'h10, 1'b0);
        chk("cw.wrapped", {24'd0, fetch_cnt}, 32'd4);

        // Random requests with occasional mid-run resets
        do_reset("rnd");
        for (int i = 0; i < 700; i++) begin
            int unsigned r;
            int unsigned t;
            bit s, b, tr;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset("rnd.rst");
            end else begin
                s  = ($urandom_range(0, 99) < 25);
                tr = ($urandom_range(0, 99) < 5);
                b  = ($urandom_range(0, 99) < 15);
                case ($urandom_range(0, 3))
                    0:       t = $urandom_range(0, 255);
                    1:       t = 252;
                    default: t = $urandom_range(0, 63) * 4;
                endcase
                step("rnd", s, b, t, tr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
